vc_arbiter: RTL and testbench
=============================

VC_ARBITER -- requirements
Module: vc_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 6: word width; bit DATA_W-1 selects the destination (0 = D0, 1 = D1).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_L, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port init, input, 1: hold request; while high, no new transfers start.
REQ-005 SHALL have port vc_empty, input, 4: empty flag per VC FIFO; bit i is VCi.
REQ-006 SHALL have port vc_data, input, 4*DATA_W: show-ahead head words; VCi occupies bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port vc_pop, output, 4: one-hot pop strobe to the VC FIFOs.
REQ-008 SHALL have port d_almost_full, input, 2: almost-full flag of destination FIFOs D0 and D1.
REQ-009 SHALL have port d_push, output, 2: one-hot push strobe to D0 or D1.
REQ-010 SHALL have port d_data, output, DATA_W: word pushed to the destination FIFO.
REQ-011 SHALL have port grant_out, output, 2: index of the last granted VC.
REQ-012 SHALL have port active_out, output, 1: high in state ACTIVE.

Function
REQ-013 SHALL define eligible[i] = !vc_empty[i] and !d_almost_full[dest(VCi head)].
REQ-014 SHALL implement FSM states INIT, IDLE and ACTIVE, with registered state.
REQ-015 SHALL transition INIT->IDLE when init is low; IDLE->ACTIVE when any eligible[i] is 1; ACTIVE->IDLE when no eligible[i] is 1; IDLE/ACTIVE->INIT when init is 1 (init has highest priority).
REQ-016 SHALL in ACTIVE with init low select one eligible VC per cycle by round-robin, starting the search at last grant + 1 mod 4 (3 wraps to 0).
REQ-017 SHALL drive vc_pop[sel] combinationally in the same cycle N as the selection; at most one vc_pop bit SHALL be high in any cycle.
REQ-018 SHALL register the popped word and its destination at the end of cycle N; d_push[dest] and d_data SHALL be valid in cycle N+1 for exactly one cycle (pop-to-push latency 1).
REQ-019 SHALL update grant_out to sel at the end of cycle N.
REQ-020 SHALL allow back-to-back grants to the same VC when it is the only eligible VC, giving one word per cycle.
REQ-021 SHALL assert no pop in IDLE or INIT; a push registered in the cycle before entering INIT SHALL still complete, so no word is lost.
REQ-022 SHALL, while d_almost_full[d] is high, never pop a word destined for d; words for the other destination SHALL continue to flow. The system provides at least 2 free entries when almost-full asserts, which covers the 1 in-flight word.
REQ-023 SHALL keep d_data at its last pushed value when d_push is 0.
REQ-024 SHALL reset the round-robin pointer to 3 in INIT, so that VC0 is searched first.

Reset
REQ-025 SHALL, on reset_L low and without waiting for clk, force state=INIT, vc_pop=0, d_push=0, d_data=0, grant_out=3, active_out=0, and the in-flight register to empty.
REQ-026 SHALL discard any pending push when reset is asserted mid-operation; the first pop after release SHALL occur no earlier than the second rising edge after reset_L rises.

Configuration
REQ-027 SHALL, with macro VC_ARB_STRICT_PRIO_EN defined, use fixed priority (VC0 highest, VC3 lowest) instead of round-robin; grant_out still reports the last grant.
REQ-028 SHALL, without VC_ARB_STRICT_PRIO_EN, use the round-robin behaviour of REQ-016.

Verification
REQ-029 SHALL cover this case: after reset with init low, all four VCs non-empty, all words to D0, D0 not full -> pops in order VC0, VC1, VC2, VC3, VC0; d_push=01 one cycle after each pop.
REQ-030 SHALL cover this case: VC1 holds 3 words for D1, other VCs empty -> vc_pop=0010 for 3 consecutive cycles; d_push=10 for 3 cycles, delayed by 1; then state IDLE and active_out=0.
REQ-031 SHALL cover this case: VC0 head to D0, VC2 head to D1, d_almost_full=01 -> only VC2 is popped; VC0 waits until d_almost_full=00, then it is popped.
REQ-032 SHALL cover this case: init raised in the same cycle as a pop of word 0x2A -> d_push and d_data=0x2A on the next cycle; no further pops while init is high.
REQ-033 SHALL cover this case: reset_L dropped between a pop and its push -> d_push=0 immediately; grant_out=3; no push after release until a new pop.
REQ-034 SHALL cover this case: with VC_ARB_STRICT_PRIO_EN, VC0 and VC3 continuously eligible -> VC0 is granted every cycle and VC3 is never granted.

Source files
------------

// File: rtl/vc_arbiter.sv
`default_nettype none
// ==========================================================================
// vc_arbiter: moves words from four show-ahead VC FIFOs into two destination
// FIFOs. Round-robin by default; VC_ARB_STRICT_PRIO_EN selects fixed priority.
// Revision: 1.0
// ==========================================================================
module vc_arbiter #(
  parameter int DATA_W = 6
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic                init,
  input  logic [3:0]          vc_empty,
  input  logic [4*DATA_W-1:0] vc_data,
  output logic [3:0]          vc_pop,
  input  logic [1:0]          d_almost_full,
  output logic [1:0]          d_push,
  output logic [DATA_W-1:0]   d_data,
  output logic [1:0]          grant_out,
  output logic                active_out
);

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t            state;
  logic [3:0]        eligible;
  logic              any_eligible;
  logic [1:0]        sel;
  logic              sel_valid;
  logic              pop_now;
  logic [DATA_W-1:0] sel_word;

  always_comb begin
    eligible = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      eligible[i] = !vc_empty[i] && !d_almost_full[vc_data[i*DATA_W + DATA_W - 1]];
    end
  end

  assign any_eligible = |eligible;

`ifdef VC_ARB_STRICT_PRIO_EN
  always_comb begin
    sel       = 2'd0;
    sel_valid = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (eligible[k]) begin
        sel       = 2'(k);
        sel_valid = 1'b1;
      end
    end
  end
`else
  logic [1:0] idx;

  // Walk from lowest to highest priority so the last hit is the winner;
  // offset 1 from the last grant is the highest priority candidate.
  always_comb begin
    sel       = 2'd0;
    sel_valid = 1'b0;
    idx       = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      idx = grant_out + 2'(k);
      if (eligible[idx]) begin
        sel       = idx;
        sel_valid = 1'b1;
      end
    end
  end
`endif

  assign pop_now  = (state == ACTIVE) && !init && sel_valid;
  assign vc_pop   = pop_now ? (4'b0001 << sel) : 4'b0000;
  assign sel_word = vc_data[int'(sel)*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state      <= INIT;
      d_push     <= 2'b00;
      d_data     <= '0;
      grant_out  <= 2'd3;
      active_out <= 1'b0;
    end else begin
      d_push <= 2'b00;
      if (pop_now) begin
        d_push    <= sel_word[DATA_W-1] ? 2'b10 : 2'b01;
        d_data    <= sel_word;
        grant_out <= sel;
      end
      case (state)
        INIT: begin
          grant_out <= 2'd3;
          if (!init) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (init) begin
            state <= INIT;
          end else if (any_eligible) begin
            state      <= ACTIVE;
            active_out <= 1'b1;
          end
        end
        ACTIVE: begin
          if (init) begin
            state      <= INIT;
            active_out <= 1'b0;
          end else if (!any_eligible) begin
            state      <= IDLE;
            active_out <= 1'b0;
          end
        end
        default: begin
          state      <= INIT;
          active_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vc_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_vc_arbiter: directed stimulus with a queue-based reference model.
// Revision: 1.0
// ==========================================================================
module tb_vc_arbiter;
  localparam int DW = 6;

  logic            clk = 1'b0;
  logic            reset_L = 1'b1;
  logic            init = 1'b0;
  logic [3:0]      vc_empty = 4'hF;
  logic [4*DW-1:0] vc_data = '0;
  logic [3:0]      vc_pop;
  logic [1:0]      d_almost_full = 2'b00;
  logic [1:0]      d_push;
  logic [DW-1:0]   d_data;
  logic [1:0]      grant_out;
  logic            active_out;

  vc_arbiter #(.DATA_W(DW)) dut (
    .clk(clk), .reset_L(reset_L), .init(init), .vc_empty(vc_empty),
    .vc_data(vc_data), .vc_pop(vc_pop), .d_almost_full(d_almost_full),
    .d_push(d_push), .d_data(d_data), .grant_out(grant_out),
    .active_out(active_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // VC FIFO contents; head is element 0
  logic [DW-1:0] vcq [4][$];
  logic [3:0]    dut_pop_l = 4'b0;

  // reference model: 0=INIT 1=IDLE 2=ACTIVE
  int            m_state = 0;
  int            m_last  = 3;
  int            m_push  = -1;
  logic [DW-1:0] m_data  = '0;
  int            exp_idx = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit elig(input int v);
    logic [DW-1:0] w;
    if (vcq[v].size() == 0) return 1'b0;
    w = vcq[v][0];
    return !d_almost_full[w[DW-1]];
  endfunction

  function automatic void drive_inputs();
    for (int i = 0; i < 4; i++) begin
      vc_empty[i] = (vcq[i].size() == 0);
      vc_data[i*DW +: DW] = (vcq[i].size() != 0) ? vcq[i][0] : '0;
    end
  endfunction

  // FIFO side: consume what the DUT popped, then present the new heads
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++)
      if (dut_pop_l[i] && reset_L && vcq[i].size() != 0) void'(vcq[i].pop_front());
    dut_pop_l = 4'b0;
    drive_inputs();
  end

  // model: compute expected pop for this cycle and compare all outputs
  always @(negedge clk) begin
    logic [3:0] exp_pop;
    exp_idx = -1;
    if (reset_L && m_state == 2 && !init) begin
`ifdef VC_ARB_STRICT_PRIO_EN
      for (int off = 0; off < 4; off++)
        if (exp_idx < 0 && elig(off)) exp_idx = off;
`else
      for (int off = 1; off <= 4; off++)
        if (exp_idx < 0 && elig((m_last + off) % 4)) exp_idx = (m_last + off) % 4;
`endif
    end
    exp_pop = (exp_idx < 0) ? 4'b0 : (4'b0001 << exp_idx);
    check("vc_pop", {28'b0, vc_pop}, {28'b0, exp_pop});
    check("d_push", {30'b0, d_push}, (m_push < 0) ? 32'd0 : (32'd1 << m_push));
    check("d_data", {26'b0, d_data}, {26'b0, m_data});
    check("grant_out", {30'b0, grant_out}, m_last);
    check("active_out", {31'b0, active_out}, {31'b0, (m_state == 2)});
    dut_pop_l = vc_pop;
  end

  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      m_state = 0; m_last = 3; m_push = -1; m_data = '0;
    end else begin
      bit any;
      logic [DW-1:0] w;
      any = 1'b0;
      for (int v = 0; v < 4; v++) any = any | elig(v);
      if (exp_idx >= 0) begin
        w = vcq[exp_idx][0];
        m_push = w[DW-1]; m_data = w; m_last = exp_idx;
      end else begin
        m_push = -1;
      end
      case (m_state)
        0: begin m_last = 3; if (!init) m_state = 1; end
        1: if (init) m_state = 0; else if (any) m_state = 2;
        default: if (init) m_state = 0; else if (!any) m_state = 1;
      endcase
    end
  end

  task automatic wait_pop(output int cnt);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (vc_pop == 4'b0 && cnt < 20);
    if (vc_pop == 4'b0) begin
      checks++; errors++;
      $display("FAIL wait_pop: got no pop within %0d cycles, expected a pop", cnt);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((vcq[0].size() + vcq[1].size() + vcq[2].size() + vcq[3].size() != 0
            || active_out || d_push != 2'b00) && n < 60) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL drain: got activity after %0d cycles, expected idle", n);
    end
  endtask

  task automatic at_edge();
    @(posedge clk); #2;
  endtask

  initial begin
    int cnt;
    logic [3:0]    seq_pop [5];
    logic [DW-1:0] seq_word [4];
`ifdef VC_ARB_STRICT_PRIO_EN
    seq_pop  = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100};
    seq_word = '{6'h01, 6'h05, 6'h02, 6'h06};
`else
    seq_pop  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    seq_word = '{6'h01, 6'h02, 6'h03, 6'h04};
`endif
    #1 reset_L = 1'b0;
    #2;
    check("rst vc_pop", {28'b0, vc_pop}, 0);
    check("rst d_push", {30'b0, d_push}, 0);
    check("rst d_data", {26'b0, d_data}, 0);
    check("rst grant_out", {30'b0, grant_out}, 3);
    check("rst active_out", {31'b0, active_out}, 0);

    // four VCs, two D0 words each; round-robin from VC0
    for (int i = 0; i < 4; i++) begin
      vcq[i].push_back(DW'(i + 1));
      vcq[i].push_back(DW'(i + 5));
    end
    drive_inputs();
    repeat (2) @(posedge clk);
    #2 reset_L = 1'b1;
    wait_pop(cnt);
    check("first pop latency", cnt, 3);
    check("rr pop 0", {28'b0, vc_pop}, {28'b0, seq_pop[0]});
    for (int c = 1; c < 5; c++) begin
      @(negedge clk);
      check("rr pop", {28'b0, vc_pop}, {28'b0, seq_pop[c]});
      check("rr push", {30'b0, d_push}, 1);
      check("rr data", {26'b0, d_data}, {26'b0, seq_word[c-1]});
    end
    drain();

    // one VC, three D1 words back to back
    at_edge();
    vcq[1].push_back(6'h21); vcq[1].push_back(6'h22); vcq[1].push_back(6'h23);
    drive_inputs();
    wait_pop(cnt);
    check("solo latency", cnt, 2);
    check("solo pop0", {28'b0, vc_pop}, 4'b0010);
    @(negedge clk);
    check("solo pop1", {28'b0, vc_pop}, 4'b0010);
    check("solo push0", {26'b0, d_data}, 6'h21);
    @(negedge clk);
    check("solo pop2", {28'b0, vc_pop}, 4'b0010);
    check("solo push1", {30'b0, d_push}, 2'b10);
    @(negedge clk);
    check("solo nopop", {28'b0, vc_pop}, 0);
    check("solo push2", {26'b0, d_data}, 6'h23);
    @(negedge clk);
    check("solo idle", {31'b0, active_out}, 0);
    check("solo hold", {26'b0, d_data}, 6'h23);
    check("solo nopush", {30'b0, d_push}, 0);

    // D0 almost full: only the D1 word moves
    at_edge();
    d_almost_full = 2'b01;
    vcq[0].push_back(6'h11); vcq[2].push_back(6'h32);
    drive_inputs();
    wait_pop(cnt);
    check("afull pop", {28'b0, vc_pop}, 4'b0100);
    @(negedge clk);
    check("afull push", {30'b0, d_push}, 2'b10);
    check("afull data", {26'b0, d_data}, 6'h32);
    repeat (2) @(negedge clk);
    check("afull blocked", {28'b0, vc_pop}, 0);
    check("afull idle", {31'b0, active_out}, 0);
    at_edge();
    d_almost_full = 2'b00;
    wait_pop(cnt);
    check("afull release", {28'b0, vc_pop}, 4'b0001);
    @(negedge clk);
    check("afull d0 push", {30'b0, d_push}, 2'b01);
    check("afull d0 data", {26'b0, d_data}, 6'h11);
    drain();

    // init raised right after the pop of 0x2A
    at_edge();
    vcq[3].push_back(6'h2A); vcq[3].push_back(6'h0B);
    drive_inputs();
    wait_pop(cnt);
    check("init pop", {28'b0, vc_pop}, 4'b1000);
    at_edge();
    init = 1'b1;
    @(negedge clk);
    check("init push", {30'b0, d_push}, 2'b10);
    check("init data", {26'b0, d_data}, 6'h2A);
    check("init nopop", {28'b0, vc_pop}, 0);
    repeat (3) @(negedge clk);
    check("init held", {28'b0, vc_pop}, 0);
    check("init grant", {30'b0, grant_out}, 3);
    at_edge();
    init = 1'b0;
    wait_pop(cnt);
    check("init resume latency", cnt, 3);
    check("init resume pop", {28'b0, vc_pop}, 4'b1000);
    drain();

    // reset between a pop and its push
    at_edge();
    vcq[0].push_back(6'h15); vcq[1].push_back(6'h16);
    drive_inputs();
    wait_pop(cnt);
    check("rst pop", {28'b0, vc_pop}, 4'b0001);
    at_edge();
    check("rst pending push", {30'b0, d_push}, 2'b01);
    reset_L = 1'b0;
    #1;
    check("rst kill push", {30'b0, d_push}, 0);
    check("rst kill grant", {30'b0, grant_out}, 3);
    repeat (2) @(posedge clk);
    #2 reset_L = 1'b1;
    wait_pop(cnt);
    check("rst resume latency", cnt, 3);
    check("rst resume pop", {28'b0, vc_pop}, 4'b0010);
    @(negedge clk);
    check("rst resume data", {26'b0, d_data}, 6'h16);
    drain();

    // mixed destinations with D1 almost full for a while
    at_edge();
    vcq[0].push_back(6'h20); vcq[0].push_back(6'h01);
    vcq[2].push_back(6'h22); vcq[2].push_back(6'h02);
    vcq[3].push_back(6'h03);
    d_almost_full = 2'b10;
    drive_inputs();
    repeat (4) at_edge();
    d_almost_full = 2'b00;
    drain();

`ifdef VC_ARB_STRICT_PRIO_EN
    at_edge();
    for (int i = 0; i < 6; i++) begin
      vcq[0].push_back(DW'(i + 1));
      vcq[3].push_back(DW'(i + 8));
    end
    drive_inputs();
    wait_pop(cnt);
    for (int c = 0; c < 5; c++) begin
      check("prio vc0", {28'b0, vc_pop}, 4'b0001);
      @(negedge clk);
    end
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
